// File: rtl/icache_r32i_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// The address is split as {tag, index, word offset, byte offset}.
package icache_r32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fill_state_t;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int data_w, input int line_words, input int num_lines);
    return data_w - 2 - off_bits(line_words) - idx_bits(num_lines);
  endfunction

endpackage

// File: rtl/icache_r32i_fill_fsm.sv
// Line-fill controller: latches the missing line address, performs the request
// handshake, steps through the response beats and drives the array write ports.
module icache_r32i_fill_fsm
  import icache_r32i_pkg::*;
#(
  parameter int dataW     = 32,
  parameter int lineWords = 4,
  parameter int numLines  = 16,
  localparam int OB = off_bits(lineWords),
  localparam int IB = idx_bits(numLines),
  localparam int TW = tag_bits(dataW, lineWords, numLines),
  localparam int LW = dataW - 2 - OB
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             miss,
  input  logic [LW-1:0]    line_addr,
  input  logic             flush,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  output logic             idle,
  output logic             mem_req_valid,
  output logic [dataW-1:0] mem_req_addr,
  output logic             fill_we,
  output logic [IB-1:0]    fill_idx,
  output logic [OB-1:0]    fill_off,
  output logic [TW-1:0]    fill_tag,
  output logic             tag_we,
  output logic             set_valid,
  output logic             clear_valid
);

  localparam logic [OB-1:0] LAST_BEAT = OB'(lineWords - 1);

  fill_state_t     state;
  logic [OB-1:0]   count;
  logic [LW-1:0]   miss_addr;
  logic            flush_pending;
  logic            beat;
  logic            last_beat;
  logic            flush_seen;

  assign idle          = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = {miss_addr, {(OB + 2){1'b0}}};

  assign beat       = (state == ST_FILL) && mem_resp_valid;
  assign last_beat  = beat && (count == LAST_BEAT);
  // A flush arriving on the final beat still counts: the line must not be validated.
  assign flush_seen = flush_pending || flush;

  assign fill_we     = beat;
  assign fill_idx    = miss_addr[IB-1:0];
  assign fill_off    = count;
  assign fill_tag    = miss_addr[LW-1:IB];
  assign tag_we      = last_beat;
  assign set_valid   = last_beat && !flush_seen;
  assign clear_valid = (idle && flush) || (last_beat && flush_seen);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      miss_addr     <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            state     <= ST_REQ;
            miss_addr <= line_addr;
          end
        end
        ST_REQ: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_req_ready) begin
            state <= ST_FILL;
            count <= '0;
          end
        end
        ST_FILL: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_resp_valid) begin
            count <= count + OB'(1);
            if (count == LAST_BEAT) begin
              state         <= ST_IDLE;
              flush_pending <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_r32i.sv
// Direct-mapped read-only instruction cache: combinational hit path to the PC,
// stall on miss while the fill controller refills the whole line.
module icache_r32i
  import icache_r32i_pkg::*;
#(
  parameter int dataW     = 32,
  parameter int lineWords = 4,
  parameter int numLines  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [dataW-1:0] Instr,
  output logic             InstrValid,
  output logic             InsCacheStall,
  output logic             MemReqValid,
  input  logic             MemReqReady,
  output logic [dataW-1:0] MemReqAddr,
  input  logic             MemRespValid,
  input  logic [dataW-1:0] MemRespData
);

  localparam int OB = off_bits(lineWords);
  localparam int IB = idx_bits(numLines);
  localparam int TW = tag_bits(dataW, lineWords, numLines);
  localparam int LW = dataW - 2 - OB;

  logic [TW-1:0]    tag;
  logic [IB-1:0]    idx;
  logic [OB-1:0]    off;
  logic             unused_byte_bits;

  logic [dataW-1:0] data_mem [numLines][lineWords];
  logic [TW-1:0]    tag_mem  [numLines];
  logic [numLines-1:0] valid_q;

  logic             idle;
  logic             tag_hit;
  logic             hit;
  logic             fill_we;
  logic [IB-1:0]    fill_idx;
  logic [OB-1:0]    fill_off;
  logic [TW-1:0]    fill_tag;
  logic             tag_we;
  logic             set_valid;
  logic             clear_valid;

  assign tag              = ProgAddr[dataW-1 -: TW];
  assign idx              = ProgAddr[2 + OB +: IB];
  assign off              = ProgAddr[2 +: OB];
  assign unused_byte_bits = ^ProgAddr[1:0];

  // A flush only masks the hit; a genuine tag miss still starts a refill.
  assign tag_hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign hit           = idle && !Flush && tag_hit;
  assign InstrValid    = hit;
  assign InsCacheStall = !hit;
  assign Instr         = hit ? data_mem[idx][off] : '0;

  icache_r32i_fill_fsm #(
    .dataW     (dataW),
    .lineWords (lineWords),
    .numLines  (numLines)
  ) u_fill_fsm (
    .clock          (clock),
    .reset          (reset),
    .miss           (idle && !tag_hit),
    .line_addr      (ProgAddr[dataW-1 -: LW]),
    .flush          (Flush),
    .mem_req_ready  (MemReqReady),
    .mem_resp_valid (MemRespValid),
    .idle           (idle),
    .mem_req_valid  (MemReqValid),
    .mem_req_addr   (MemReqAddr),
    .fill_we        (fill_we),
    .fill_idx       (fill_idx),
    .fill_off       (fill_off),
    .fill_tag       (fill_tag),
    .tag_we         (tag_we),
    .set_valid      (set_valid),
    .clear_valid    (clear_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            valid_q <= '0;
    else if (clear_valid) valid_q <= '0;
    else if (set_valid)   valid_q[fill_idx] <= 1'b1;
  end

  // NOTE: data and tag arrays are deliberately not reset; valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (fill_we) data_mem[fill_idx][fill_off] <= MemRespData;
    if (tag_we)  tag_mem[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_r32i.sv
// Directed self-checking bench for icache_r32i: cold miss, conflict, backpressure,
// slow beats, flush during fill / in idle / on last beat, and reset mid-fill.
module tb_icache_r32i;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InsCacheStall;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [31:0] MemReqAddr;
  logic        MemRespValid;
  logic [31:0] MemRespData;

  int n_checks = 0;
  int n_fail   = 0;

  icache_r32i dut (
    .clock         (clock),
    .reset         (reset),
    .ProgAddr      (ProgAddr),
    .Flush         (Flush),
    .Instr         (Instr),
    .InstrValid    (InstrValid),
    .InsCacheStall (InsCacheStall),
    .MemReqValid   (MemReqValid),
    .MemReqReady   (MemReqReady),
    .MemReqAddr    (MemReqAddr),
    .MemRespValid  (MemRespValid),
    .MemRespData   (MemRespData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    ProgAddr = addr;
    #1;
    check($sformatf("hit valid @%0h", addr), InstrValid, 1);
    check($sformatf("hit stall @%0h", addr), InsCacheStall, 0);
    check($sformatf("hit instr @%0h", addr), Instr, data);
  endtask

  task automatic expect_miss(input logic [31:0] addr);
    ProgAddr = addr;
    #1;
    check($sformatf("miss valid @%0h", addr), InstrValid, 0);
    check($sformatf("miss stall @%0h", addr), InsCacheStall, 1);
    check($sformatf("miss instr @%0h", addr), Instr, 0);
  endtask

  // Serves one line fill starting from the IDLE miss cycle. Beat i is preceded by
  // (slow ? i : 0) idle cycles; Flush is pulsed together with beat flush_beat.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input int req_low,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input bit slow, input int flush_beat);
    logic [31:0] w [4];
    int n = 0;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    #1;
    while (!MemReqValid && n < 8) begin
      tick();
      n++;
    end
    check({tag, " req valid"}, MemReqValid, 1);
    check({tag, " req addr"}, MemReqAddr, exp_addr);
    check({tag, " req stall"}, InsCacheStall, 1);
    for (int k = 1; k < req_low; k++) begin
      tick();
      check($sformatf("%s hold valid c%0d", tag, k), MemReqValid, 1);
      check($sformatf("%s hold addr c%0d", tag, k), MemReqAddr, exp_addr);
    end
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < (slow ? i : 0); g++) begin
        check($sformatf("%s gap stall b%0d", tag, i), InsCacheStall, 1);
        tick();
      end
      MemRespValid = 1'b1;
      MemRespData  = w[i];
      Flush        = (i == flush_beat);
      #1;
      check($sformatf("%s fill stall b%0d", tag, i), InsCacheStall, 1);
      tick();
      MemRespValid = 1'b0;
      MemRespData  = '0;
      Flush        = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    ProgAddr     = '0;
    Flush        = 1'b0;
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;
    MemRespData  = '0;
    tick();
    tick();
    check("reset InstrValid", InstrValid, 0);
    check("reset Instr", Instr, 0);
    check("reset stall", InsCacheStall, 1);
    check("reset MemReqValid", MemReqValid, 0);
    reset = 1'b0;

    // Cold miss at 0x0
    ProgAddr = 32'h0;
    #1;
    check("cold miss-cycle stall", InsCacheStall, 1);
    check("cold miss-cycle no req yet", MemReqValid, 0);
    serve("cold", 32'h0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, -1);
    expect_hit(32'h0, 32'h11);
    expect_hit(32'h4, 32'h22);
    expect_hit(32'h8, 32'h33);
    expect_hit(32'hC, 32'h44);

    // Conflict: 0x100 shares index 0 with 0x0
    expect_miss(32'h100);
    serve("conflict", 32'h100, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0, -1);
    expect_hit(32'h100, 32'hA0);
    expect_hit(32'h10C, 32'hA3);
    expect_miss(32'h0);
    serve("evicted", 32'h0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, -1);
    expect_hit(32'h4, 32'h22);

    // Backpressure: ready low for 5 REQ cycles
    expect_miss(32'h24);
    serve("bp", 32'h20, 5, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b0, -1);
    expect_hit(32'h24, 32'hB1);
    expect_hit(32'h20, 32'hB0);

    // Slow beats, then a stray beat while idle
    ProgAddr = 32'h30;
    serve("slow", 32'h30, 0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b1, -1);
    expect_hit(32'h30, 32'hC0);
    expect_hit(32'h38, 32'hC2);
    expect_hit(32'h3C, 32'hC3);
    MemRespValid = 1'b1;
    MemRespData  = 32'hDEADBEEF;
    tick();
    MemRespValid = 1'b0;
    MemRespData  = '0;
    expect_hit(32'h30, 32'hC0);
    expect_hit(32'h34, 32'hC1);

    // Flush during fill at beat 2
    ProgAddr = 32'h40;
    serve("flushfill", 32'h40, 0, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 1'b0, 2);
    expect_miss(32'h40);
    expect_miss(32'h0);
    expect_miss(32'h30);
    ProgAddr = 32'h40;
    serve("refill40", 32'h40, 0, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b0, -1);
    expect_hit(32'h40, 32'hF0);
    expect_hit(32'h4C, 32'hF3);

    // Reset after 2 beats of a fill
    ProgAddr = 32'h0;
    tick();
    check("rst pre req valid", MemReqValid, 1);
    MemReqReady = 1'b1;
    tick();
    MemReqReady  = 1'b0;
    MemRespValid = 1'b1;
    MemRespData  = 32'h60;
    tick();
    MemRespData  = 32'h61;
    tick();
    MemRespValid = 1'b0;
    ProgAddr     = 32'h40;
    reset        = 1'b1;
    #1;
    check("rst async InstrValid", InstrValid, 0);
    check("rst async Instr", Instr, 0);
    check("rst async stall", InsCacheStall, 1);
    check("rst async MemReqValid", MemReqValid, 0);
    tick();
    reset = 1'b0;
    expect_miss(32'h40);
    ProgAddr = 32'h0;
    serve("rst refill", 32'h0, 0, 32'h70, 32'h71, 32'h72, 32'h73, 1'b0, -1);
    expect_hit(32'h0, 32'h70);
    expect_hit(32'h4, 32'h71);
    expect_hit(32'hC, 32'h73);

    // Flush in IDLE suppresses the hit in its own cycle and clears valid bits
    expect_hit(32'h8, 32'h72);
    Flush = 1'b1;
    #1;
    check("idle flush InstrValid", InstrValid, 0);
    check("idle flush stall", InsCacheStall, 1);
    tick();
    Flush = 1'b0;
    #1;
    check("after flush InstrValid", InstrValid, 0);
    check("after flush no req yet", MemReqValid, 0);

    // Flush coinciding with the last beat: line stays invalid
    serve("lastflush", 32'h0, 0, 32'h80, 32'h81, 32'h82, 32'h83, 1'b0, 3);
    expect_miss(32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_r32i.md
Name: icache_r32i

Overview:
Direct-mapped, read-only instruction cache that answers the PC's fetch address and drives InsCacheStall back to the PC. Hits return the instruction combinationally in the same cycle. A miss stalls the PC, fetches the whole line from the memory side over a valid/ready request and an in-order response beat stream, then resumes. It sits between the PC and the instruction memory/bus adapter.

Parameters:
dataW, 32, instruction/data/address width (only 32 supported)
lineWords, 4, 32-bit words per line (power of 2, at least 2)
numLines, 16, number of lines (power of 2, at least 2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ProgAddr  input  dataW  fetch address from the PC; bits [1:0] ignored
Flush  input  1  invalidate all lines (fence.i)
Instr  output  dataW  fetched instruction; 0 when InstrValid=0
InstrValid  output  1  Instr is valid this cycle (hit and state IDLE)
InsCacheStall  output  1  PC must hold; equals !InstrValid
MemReqValid  output  1  line-fill request valid
MemReqReady  input  1  memory accepts request
MemReqAddr  output  dataW  line-aligned fill address; low log2(lineWords)+2 bits are 0
MemRespValid  input  1  response beat valid
MemRespData  input  dataW  response word; beats arrive in ascending word order

Behaviour:
- Address split: off = ProgAddr[2 +: OB], OB=log2(lineWords); idx = next IB bits, IB=log2(numLines); tag = remaining upper bits.
- Storage: data array numLines x lineWords x dataW, tag array, valid bit per line. Only valid bits are reset.
- Hit = state IDLE && valid[idx] && tag matches. On hit, Instr = data[idx][off], InstrValid=1, InsCacheStall=0, all combinational with zero latency.
- Reset (asynchronous): state IDLE, all valid bits 0, beat counter 0, MemReqValid 0, flush-pending 0. Resulting outputs: InstrValid 0, Instr 0, InsCacheStall 1.
- FSM:
  IDLE: on miss, latch line address {tag,idx} into missAddr and go to REQ. The stall is already high during the miss cycle.
  REQ: MemReqValid=1, MemReqAddr=missAddr with zeroed offset bits, both held stable until MemReqReady=1. On the accepting edge, go to FILL with counter 0.
  FILL: each MemRespValid beat writes data[missIdx][counter] and increments the counter. On beat lineWords-1, write tag[missIdx] and set valid[missIdx]=1 unless flush is pending, then go to IDLE.
- Miss-to-hit latency with zero memory wait: miss cycle, then 1 REQ cycle, then lineWords FILL cycles; the hit occurs the cycle after returning to IDLE.
- InsCacheStall=1 in every cycle of REQ and FILL.
- In IDLE the hit is re-evaluated against the current ProgAddr. A different address on return misses again; this is legal, with no special case.
- MemRespValid outside FILL is ignored. MemReqReady outside REQ is ignored.
- Flush:
  - In IDLE: all valid bits clear at the next edge, and the hit is suppressed in the Flush cycle (stall=1).
  - In REQ/FILL: set flush-pending. The fill completes its memory transaction normally, but the filled line is not marked valid. All valid bits clear on completion and flush-pending clears.
- Flush coinciding with the last fill beat counts as pending: the line is not validated.
- Reset mid-REQ/FILL aborts immediately with no completion of the memory transaction. The memory side shares the same reset.
- Counter width is OB bits. It wraps to 0 after the last beat and does not overflow into idx.

Decomposition:
- Package icache_r32i_pkg: FSM state enum {IDLE, REQ, FILL}; functions deriving OB, IB and tag width from the parameters.
- One sub-module, icache_r32i_fill_fsm: state register, beat counter, missAddr latch, flush-pending, memory handshake signals, and write-enable/address to the arrays.
- Arrays and hit compare stay in the top level.

Test Plan:
- Cold miss at ProgAddr 0x0: expect stall=1 and MemReqValid with addr 0x0. Feed beats 0x11,0x22,0x33,0x44. Then addresses 0x0/0x4/0x8/0xC must hit with stall=0 and return 0x11/0x22/0x33/0x44.
- Conflict (default parameters): after the line at 0x0 is filled, fetch 0x100 (same idx 0, different tag). Expect a miss and request addr 0x100. After refill with 0xA0..0xA3, fetch 0x0 again: expect a miss and a request for 0x0.
- Backpressure: miss at 0x24, MemReqReady held low 5 cycles. Expect MemReqValid=1 and MemReqAddr=0x20 stable all 5 cycles, with no state advance until ready.
- Slow beats: MemRespValid gaps of 0-3 cycles between beats, plus a stray beat injected in IDLE. Expect correct word placement, stall held throughout, and the stray beat ignored.
- Flush during FILL at beat 2 of a 0x40 fill: the fill completes, but the next fetch of 0x40 misses again. Lines filled before the flush also miss.
- Reset asserted mid-FILL after 2 beats: outputs go to their reset values immediately and the old line is invalid. The first fetch after deassert re-requests the full line.
